// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD read scheduler: state encoding,
// burst shift and frame-geometry widths.
package lcd_sched_pkg;

    localparam int FW_W          = 22;
    localparam int PAD_W         = 20;
    localparam int DEF_BURST_LEN = 256;
    localparam int BURST_SHIFT   = $clog2(DEF_BURST_LEN);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLUSH      = 3'd1,
        ST_WAIT_SPACE = 3'd2,
        ST_REQ        = 3'd3,
        ST_BURST      = 3'd4,
        ST_FRAME_END  = 3'd5
    } sched_state_e;

endpackage

// File: rtl/lcd_frame_geom.sv
// Combinational frame geometry: pixel count, whole bursts needed to cover it,
// and the pad words that round the frame up to a burst boundary.
module lcd_frame_geom
    import lcd_sched_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic [10:0]      h_disp_i,
    input  logic [10:0]      v_disp_i,
    output logic [FW_W-1:0]  frame_words_o,
    output logic [FW_W-1:0]  bursts_o,
    output logic [PAD_W-1:0] pad_o
);

    localparam int SHIFT = $clog2(BURST_LEN);

    logic [FW_W:0] rounded;
    logic [FW_W:0] span;

    always_comb begin
        frame_words_o = {11'd0, h_disp_i} * {11'd0, v_disp_i};
        // One spare bit so the round-up add cannot overflow.
        rounded       = {1'b0, frame_words_o} + (FW_W + 1)'(BURST_LEN - 1);
        bursts_o      = FW_W'(rounded >> SHIFT);
        span          = {1'b0, bursts_o} << SHIFT;
        pad_o         = PAD_W'(span - {1'b0, frame_words_o});
    end

endmodule

// File: rtl/lcd_rd_scheduler.sv
// Frame-level SDRAM read scheduler feeding the LCD display FIFO.
// Define LCD_PINGPONG_EN for two-bank ping-pong reads with bank swapping.
module lcd_rd_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int                ADDR_W      = 24,
    parameter int                BURST_LEN   = DEF_BURST_LEN,
    parameter int                FIFO_DEPTH  = 1024,
    parameter int                FIFO_LW     = 11,
    parameter logic [ADDR_W-1:0] BANK_OFFSET = 24'h100000
) (
    input  logic               lcd_pclk,
    input  logic               rst_n,
    input  logic [10:0]        i_h_disp,
    input  logic [10:0]        i_v_disp,
    input  logic               frame_start,
    input  logic               input_done,
    input  logic               wr_frame_done,
    input  logic [FIFO_LW-1:0] fifo_level,
    output logic               rd_req,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_ack,
    input  logic               rd_done,
    output logic               fifo_flush,
    output logic               rd_bank,
    output logic               wr_bank,
    output logic [PAD_W-1:0]   fifo_left_s,
    output logic               underrun,
    output logic [2:0]         dbg_state_o
);

    localparam logic [FIFO_LW:0]  SPACE_THR = (FIFO_LW + 1)'(FIFO_DEPTH - BURST_LEN);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);

    sched_state_e      state_q, state_d;
    logic [FW_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [FW_W-1:0]   bursts_q, bursts_d;
    logic [PAD_W-1:0]  pad_q, pad_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              underrun_q, underrun_d;
    logic              restart_q, restart_d;
    logic              flush_bank;
    logic              space_ok;
    logic [FW_W-1:0]   geom_fw_unused;
    logic [FW_W-1:0]   geom_bursts;
    logic [PAD_W-1:0]  geom_pad;

    lcd_frame_geom #(.BURST_LEN(BURST_LEN)) u_geom (
        .h_disp_i      (i_h_disp),
        .v_disp_i      (i_v_disp),
        .frame_words_o (geom_fw_unused),
        .bursts_o      (geom_bursts),
        .pad_o         (geom_pad)
    );

    assign space_ok = {1'b0, fifo_level} <= SPACE_THR;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        bursts_d    = bursts_q;
        pad_d       = pad_q;
        addr_d      = addr_q;
        underrun_d  = underrun_q;
        restart_d   = restart_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start && input_done) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                bursts_d    = geom_bursts;
                pad_d       = geom_pad;
                burst_cnt_d = '0;
                addr_d      = flush_bank ? BANK_OFFSET : '0;
                restart_d   = 1'b0;
                state_d     = ST_WAIT_SPACE;
            end
            ST_WAIT_SPACE: begin
                // A frame that already issued every burst is not an underrun.
                if (frame_start) begin
                    state_d = ST_FLUSH;
                    if (burst_cnt_q != bursts_q) underrun_d = 1'b1;
                end else if (burst_cnt_q == bursts_q) begin
                    state_d = ST_FRAME_END;
                end else if (space_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    state_d = ST_BURST;
                    if (frame_start) begin
                        restart_d  = 1'b1;
                        underrun_d = 1'b1;
                    end
                end else if (frame_start) begin
                    state_d    = ST_FLUSH;
                    underrun_d = 1'b1;
                end
            end
            ST_BURST: begin
                if (frame_start) begin
                    restart_d  = 1'b1;
                    underrun_d = 1'b1;
                end
                if (rd_done) begin
                    burst_cnt_d = burst_cnt_q + FW_W'(1);
                    addr_d      = addr_q + ADDR_STEP;
                    state_d     = (restart_q || frame_start) ? ST_FLUSH : ST_WAIT_SPACE;
                end
            end
            ST_FRAME_END: begin
                if (frame_start) state_d = input_done ? ST_FLUSH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            bursts_q    <= '0;
            pad_q       <= '0;
            addr_q      <= '0;
            underrun_q  <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            bursts_q    <= bursts_d;
            pad_q       <= pad_d;
            addr_q      <= addr_d;
            underrun_q  <= underrun_d;
            restart_q   <= restart_d;
        end
    end

`ifdef LCD_PINGPONG_EN
    logic rd_bank_q, rd_bank_d;
    logic swap_pend_q, swap_pend_d;

    // A writer completion arriving in the FLUSH cycle itself swaps immediately.
    always_comb begin
        rd_bank_d   = rd_bank_q;
        swap_pend_d = swap_pend_q | wr_frame_done;
        if (state_q == ST_FLUSH) begin
            rd_bank_d   = rd_bank_q ^ (swap_pend_q | wr_frame_done);
            swap_pend_d = 1'b0;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank_q   <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            rd_bank_q   <= rd_bank_d;
            swap_pend_q <= swap_pend_d;
        end
    end

    assign flush_bank = rd_bank_d;
    assign rd_bank    = rd_bank_q;
    assign wr_bank    = ~rd_bank_q;
`else
    logic wr_frame_done_unused;

    assign wr_frame_done_unused = wr_frame_done;
    assign flush_bank           = 1'b0;
    assign rd_bank              = 1'b0;
    assign wr_bank              = 1'b0;
`endif

    assign rd_req      = (state_q == ST_REQ);
    assign fifo_flush  = (state_q == ST_FLUSH);
    assign rd_addr     = addr_q;
    assign fifo_left_s = pad_q;
    assign underrun    = underrun_q;
    assign dbg_state_o = state_q;

endmodule
